// File: rtl/peakdet_env_buffer.sv
// peakdet_env_buffer: circular min/max envelope capture around a trigger, read back oldest first
module peakdet_env_buffer #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_min,
  input  logic [DW-1:0] din_max,
  input  logic          clken,
  input  logic          start,
  input  logic [AW:0]   pretrig_len,
  input  logic          trig,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_min,
  output logic [DW-1:0] rd_max,
  output logic [AW-1:0] trig_addr,
  output logic          busy,
  output logic          done
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] MAX_PRE = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;
  state_t r_state, w_next;
  logic [2*DW-1:0] r_mem [DEPTH];
  logic [2*DW-1:0] r_rd;
  logic [AW-1:0] r_wr_ptr, r_trig_addr, w_rd_phys;
  logic [AW:0] r_cnt, r_pre_len, w_pre_req, w_post_len, w_cnt_inc;
  logic w_accept, w_wr, w_trig_hit;
  always_comb begin
    w_pre_req = pretrig_len > MAX_PRE ? MAX_PRE : pretrig_len;
    w_post_len = FULL - r_pre_len;
    w_cnt_inc = r_cnt + ONE;
    w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    w_wr = clken && (r_state inside {S_PRE, S_WAIT, S_POST});
    w_trig_hit = trig && r_state == S_WAIT;
    w_rd_phys = r_trig_addr - r_pre_len[AW-1:0] + rd_addr;
    w_next = r_state;
    if (w_accept)
      w_next = w_pre_req == '0 ? S_WAIT : S_PRE;
    else if (r_state == S_PRE && clken && w_cnt_inc == r_pre_len)
      w_next = S_WAIT;
    else if (w_trig_hit)
      w_next = (clken && w_post_len == ONE) ? S_DONE : S_POST;
    else if (r_state == S_POST && clken && w_cnt_inc == w_post_len)
      w_next = S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr_ptr <= '0;
      r_cnt <= '0;
      r_pre_len <= '0;
      r_trig_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wr_ptr <= '0;
        r_cnt <= '0;
        r_pre_len <= w_pre_req;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_trig_hit) begin
          r_trig_addr <= r_wr_ptr;
          r_cnt <= {{AW{1'b0}}, clken};
        end else if (w_wr && r_state != S_WAIT) begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= {din_max, din_min};
  always_ff @(posedge clk)
    r_rd <= rst ? '0 : r_mem[w_rd_phys];
  assign rd_min = r_rd[DW-1:0];
  assign rd_max = r_rd[2*DW-1:DW];
  assign trig_addr = r_trig_addr;
  assign busy = r_state inside {S_PRE, S_WAIT, S_POST};
  assign done = r_state == S_DONE;
endmodule

// File: tb/tb_peakdet_env_buffer.sv
// tb_peakdet_env_buffer: directed capture scenarios with hand-computed readout at AW=4
module tb_peakdet_env_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] din_min = '0, din_max = '0;
  logic clken = 1'b0, start = 1'b0, trig = 1'b0;
  logic [4:0] pretrig_len = '0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_min, rd_max;
  logic [3:0] trig_addr;
  logic busy, done;
  int errors = 0;
  int checks = 0;
  int n;
  peakdet_env_buffer #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .din_min(din_min), .din_max(din_max), .clken(clken),
    .start(start), .pretrig_len(pretrig_len), .trig(trig), .rd_addr(rd_addr),
    .rd_min(rd_min), .rd_max(rd_max), .trig_addr(trig_addr), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic drive(input bit ce, input int k, input bit tr, input bit st);
    @(negedge clk);
    clken = ce;
    din_min = 8'(k);
    din_max = 8'(k + 100);
    trig = tr;
    start = st;
    @(posedge clk);
    #1;
  endtask
  task automatic cap(input int pre, input int trig_k, input int early_k, input int gap,
                     input bit trig_gap, input int start_k, input int limit, output int cnt);
    pretrig_len = 5'(pre);
    drive(0, 0, 0, 1);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    cnt = 0;
    for (int k = 0; k < limit && !done; k++) begin
      for (int g = 0; g < gap; g++)
        drive(0, k, trig_gap && k == trig_k && g == gap - 1, 0);
      drive(1, k, !trig_gap && (k == trig_k || k == early_k), k == start_k);
      cnt++;
    end
  endtask
  task automatic readchk(input int base);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = 4'(i);
      #1;
      if (i > 0) chk("rd_latency", rd_min, base + i - 1);
      @(posedge clk);
      #1;
      chk("rd_min", rd_min, base + i);
      chk("rd_max", rd_max, base + i + 100);
    end
  endtask
  task automatic post(input int writes, input int ta, input int base);
    chk("writes", n, writes);
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("trig_addr", trig_addr, ta);
    readchk(base);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_rd_min", rd_min, 0);
    chk("rst_rd_max", rd_max, 0);
    rst = 1'b0;
    cap(4, 10, -1, 0, 0, -1, 100, n);
    post(22, 10, 6);
    cap(4, 10, 2, 0, 0, -1, 100, n);
    post(22, 10, 6);
    cap(0, 3, -1, 0, 0, -1, 100, n);
    post(19, 3, 3);
    cap(20, 20, -1, 0, 0, -1, 100, n);
    post(21, 4, 5);
    cap(4, 10, -1, 3, 1, -1, 100, n);
    post(22, 10, 6);
    cap(4, 10, -1, 3, 0, -1, 100, n);
    post(22, 10, 6);
    cap(4, 10, -1, 0, 0, -1, 14, n);
    chk("mid_post_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_trig_addr", trig_addr, 0);
    chk("rst2_rd_min", rd_min, 0);
    rst = 1'b0;
    drive(1, 50, 1, 0);
    chk("idle_busy", busy, 0);
    cap(4, 10, -1, 0, 0, 2, 100, n);
    post(22, 10, 6);
    for (int j = 0; j < 8; j++) drive(1, 200 + j, 1, 0);
    chk("hold_done", done, 1);
    chk("hold_trig_addr", trig_addr, 10);
    readchk(6);
    cap(4, 10, -1, 0, 0, -1, 100, n);
    post(22, 10, 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
